// File: rtl/elgamal_pkg.sv
// ----------------------------------------------------------------------------
// elgamal_pkg
// Shared definitions for the ElGamal operation sequencer:
//   - operation codes presented on op_code
//   - error codes reported on err_code
//   - sequencer FSM state encoding
//   - step indices used to pick operands inside a multi-step operation
//   - request validation helper
// Optional feature macro used by the sequencer: ELGAMAL_TIMEOUT_EN.
// ----------------------------------------------------------------------------
package elgamal_pkg;

    // Operation codes
    localparam logic [1:0] OP_KEYGEN   = 2'd0;
    localparam logic [1:0] OP_ENCRYPT  = 2'd1;
    localparam logic [1:0] OP_DECRYPT  = 2'd2;
    localparam logic [1:0] OP_RESERVED = 2'd3;

    // Error codes
    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_BAD_OP  = 2'd1;
    localparam logic [1:0] ERR_BAD_MOD = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    // Sequencer states
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_EXP_ISSUE = 3'd1,
        ST_EXP_WAIT  = 3'd2,
        ST_MUL_ISSUE = 3'd3,
        ST_MUL_WAIT  = 3'd4,
        ST_DONE      = 3'd5
    } state_t;

    // Exponentiation step index within an operation
    localparam logic STEP_FIRST  = 1'b0;
    localparam logic STEP_SECOND = 1'b1;

    // A reserved op code outranks a bad modulus when both are present.
    function automatic logic [1:0] check_request(input logic [1:0] op,
                                                 input logic       modulus_too_small);
        if (op == OP_RESERVED)
            return ERR_BAD_OP;
        if (modulus_too_small)
            return ERR_BAD_MOD;
        return ERR_NONE;
    endfunction

endpackage

// File: rtl/elgamal_watchdog.sv
// ----------------------------------------------------------------------------
// elgamal_watchdog
// Per-wait cycle counter. Cleared by load, advanced on every count_en cycle,
// and flags expired during the LIMIT-th consecutive count_en cycle.
// Only instantiated when ELGAMAL_TIMEOUT_EN is defined.
// Ports:
//   clk      in  clock, posedge
//   rst_n    in  synchronous active-low reset
//   load     in  clear the counter (asserted in the cycle before a wait starts)
//   count_en in  a wait cycle is in progress
//   expired  out this wait cycle is the last one allowed
// ----------------------------------------------------------------------------
module elgamal_watchdog #(
    parameter int LIMIT = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic count_en,
    output logic expired
);

    localparam int CW = (LIMIT < 2) ? 1 : $clog2(LIMIT);

    logic [CW-1:0] count_q;

    // count_q holds the number of wait cycles already completed, so the
    // LIMIT-th wait cycle sees LIMIT-1.
    assign expired = count_en && (count_q == CW'(LIMIT - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= '0;
        end else if (count_en && !expired) begin
            count_q <= count_q + CW'(1);
        end
    end

endmodule

// File: rtl/elgamal_sequencer.sv
// ----------------------------------------------------------------------------
// elgamal_sequencer
// Drives one shared modular exponentiation engine and one modular multiplier
// through the ElGamal operations KEYGEN, ENCRYPT and DECRYPT (all mod q).
//   KEYGEN : res0 = g^a                      res1 = 0
//   ENCRYPT: res0 = g^k                      res1 = m * y^k
//   DECRYPT: res0 = c2 * (c1^a)^(q-2)        res1 = 0
// Optional macro ELGAMAL_TIMEOUT_EN bounds each engine wait to TIMEOUT_CYCLES
// cycles (err_code 3 on expiry); without it waits block indefinitely.
// Ports:
//   clk, rst_n                     clock (posedge), synchronous active-low reset
//   op_start/op_ready/op_code      request handshake, op code
//   in_g,in_q,in_x,in_k,in_m,in_c1,in_c2,in_y  operation operands
//   exp_start/exp_base/exp_exp/exp_mod/exp_done/exp_result  exponentiator
//   mul_start/mul_a/mul_b/mul_mod/mul_done/mul_result       multiplier
//   done/err/err_code              completion pulse and status
//   res0/res1                      results, held until the next acceptance
// ----------------------------------------------------------------------------
module elgamal_sequencer
    import elgamal_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             op_start,
    output logic             op_ready,
    input  logic [1:0]       op_code,
    input  logic [WIDTH-1:0] in_g,
    input  logic [WIDTH-1:0] in_q,
    input  logic [WIDTH-1:0] in_x,
    input  logic [WIDTH-1:0] in_k,
    input  logic [WIDTH-1:0] in_m,
    input  logic [WIDTH-1:0] in_c1,
    input  logic [WIDTH-1:0] in_c2,
    input  logic [WIDTH-1:0] in_y,
    output logic             exp_start,
    output logic [WIDTH-1:0] exp_base,
    output logic [WIDTH-1:0] exp_exp,
    output logic [WIDTH-1:0] exp_mod,
    input  logic             exp_done,
    input  logic [WIDTH-1:0] exp_result,
    output logic             mul_start,
    output logic [WIDTH-1:0] mul_a,
    output logic [WIDTH-1:0] mul_b,
    output logic [WIDTH-1:0] mul_mod,
    input  logic             mul_done,
    input  logic [WIDTH-1:0] mul_result,
    output logic             done,
    output logic             err,
    output logic [1:0]       err_code,
    output logic [WIDTH-1:0] res0,
    output logic [WIDTH-1:0] res1
);

    state_t           state_q, state_d;
    logic             step_q, step_d;
    logic [WIDTH-1:0] exp_base_q, exp_base_d;
    logic [WIDTH-1:0] exp_exp_q, exp_exp_d;
    logic [WIDTH-1:0] exp_mod_q, exp_mod_d;
    logic [WIDTH-1:0] mul_a_q, mul_a_d;
    logic [WIDTH-1:0] mul_b_q, mul_b_d;
    logic [WIDTH-1:0] mul_mod_q, mul_mod_d;
    logic [WIDTH-1:0] res0_q, res0_d;
    logic [WIDTH-1:0] res1_q, res1_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;

    // Captured request operands (only those needed after the first step)
    logic [1:0]       op_r;
    logic [WIDTH-1:0] q_r, k_r, m_r, c2_r, y_r;
    // First-step exponentiation result: c1 for ENCRYPT, s for DECRYPT
    logic [WIDTH-1:0] tmp_q, tmp_d;

    logic             capture;
    logic [1:0]       req_code;
    logic             timeout_hit;

`ifdef ELGAMAL_TIMEOUT_EN
    logic wd_load;
    logic wd_count;

    assign wd_load  = (state_q == ST_EXP_ISSUE) || (state_q == ST_MUL_ISSUE);
    assign wd_count = (state_q == ST_EXP_WAIT)  || (state_q == ST_MUL_WAIT);

    elgamal_watchdog #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk     (clk),
        .rst_n   (rst_n),
        .load    (wd_load),
        .count_en(wd_count),
        .expired (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif

    assign req_code = check_request(op_code, in_q < WIDTH'(3));

    // ---------------- next-state / operand selection ----------------
    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        tmp_d      = tmp_q;
        exp_base_d = exp_base_q;
        exp_exp_d  = exp_exp_q;
        exp_mod_d  = exp_mod_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        mul_mod_d  = mul_mod_q;
        res0_d     = res0_q;
        res1_d     = res1_q;
        err_d      = 1'b0;
        err_code_d = err_code_q;
        capture    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (op_start) begin
                    capture = 1'b1;
                    if (req_code != ERR_NONE) begin
                        state_d    = ST_DONE;
                        err_d      = 1'b1;
                        err_code_d = req_code;
                        res0_d     = '0;
                        res1_d     = '0;
                    end else begin
                        state_d    = ST_EXP_ISSUE;
                        step_d     = STEP_FIRST;
                        err_code_d = ERR_NONE;
                        exp_mod_d  = in_q;
                        // First exponentiation comes straight from the request
                        if (op_code == OP_DECRYPT) begin
                            exp_base_d = in_c1;
                            exp_exp_d  = in_x;
                        end else if (op_code == OP_ENCRYPT) begin
                            exp_base_d = in_g;
                            exp_exp_d  = in_k;
                        end else begin
                            exp_base_d = in_g;
                            exp_exp_d  = in_x;
                        end
                    end
                end
            end

            ST_EXP_ISSUE: state_d = ST_EXP_WAIT;

            ST_EXP_WAIT: begin
                if (exp_done) begin
                    if (op_r == OP_KEYGEN) begin
                        state_d = ST_DONE;
                        res0_d  = exp_result;
                        res1_d  = '0;
                    end else if (step_q == STEP_FIRST) begin
                        state_d = ST_EXP_ISSUE;
                        step_d  = STEP_SECOND;
                        tmp_d   = exp_result;
                        if (op_r == OP_ENCRYPT) begin
                            exp_base_d = y_r;
                            exp_exp_d  = k_r;
                        end else begin
                            // Fermat inverse: s^(q-2); q >= 3 so no wrap
                            exp_base_d = exp_result;
                            exp_exp_d  = q_r - WIDTH'(2);
                        end
                    end else begin
                        state_d   = ST_MUL_ISSUE;
                        mul_mod_d = q_r;
                        mul_b_d   = exp_result;
                        mul_a_d   = (op_r == OP_ENCRYPT) ? m_r : c2_r;
                    end
                end else if (timeout_hit) begin
                    state_d    = ST_DONE;
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    res0_d     = '0;
                    res1_d     = '0;
                end
            end

            ST_MUL_ISSUE: state_d = ST_MUL_WAIT;

            ST_MUL_WAIT: begin
                if (mul_done) begin
                    state_d = ST_DONE;
                    if (op_r == OP_ENCRYPT) begin
                        res0_d = tmp_q;
                        res1_d = mul_result;
                    end else begin
                        res0_d = mul_result;
                        res1_d = '0;
                    end
                end else if (timeout_hit) begin
                    state_d    = ST_DONE;
                    err_d      = 1'b1;
                    err_code_d = ERR_TIMEOUT;
                    res0_d     = '0;
                    res1_d     = '0;
                end
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase
    end

    // ---------------- registered state and outputs ----------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            step_q     <= STEP_FIRST;
            exp_base_q <= '0;
            exp_exp_q  <= '0;
            exp_mod_q  <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            mul_mod_q  <= '0;
            res0_q     <= '0;
            res1_q     <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            exp_base_q <= exp_base_d;
            exp_exp_q  <= exp_exp_d;
            exp_mod_q  <= exp_mod_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            mul_mod_q  <= mul_mod_d;
            res0_q     <= res0_d;
            res1_q     <= res1_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    // Operand capture and intermediate storage carry no reset: they are
    // always written before being read within an operation.
    always_ff @(posedge clk) begin
        tmp_q <= tmp_d;
        if (capture) begin
            op_r <= op_code;
            q_r  <= in_q;
            k_r  <= in_k;
            m_r  <= in_m;
            c2_r <= in_c2;
            y_r  <= in_y;
        end
    end

    assign op_ready  = (state_q == ST_IDLE);
    assign exp_start = (state_q == ST_EXP_ISSUE);
    assign mul_start = (state_q == ST_MUL_ISSUE);
    assign done      = (state_q == ST_DONE);
    assign err       = err_q;
    assign err_code  = err_code_q;
    assign res0      = res0_q;
    assign res1      = res1_q;
    assign exp_base  = exp_base_q;
    assign exp_exp   = exp_exp_q;
    assign exp_mod   = exp_mod_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign mul_mod   = mul_mod_q;

endmodule
